// File: rtl/dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dma_ctrl
// Purpose  : Streaming DMA initiator. Loads an even number of words from an
//            upstream valid/ready stream into memory, then walks the memory
//            controller through transfer / process / process-done condition
//            codes once per operand pair, waiting on the FPU for each pair.
// Ports    : dma_clk, dma_reset (sync, active-low)
//            dma_start, dma_len             job request
//            dma_src_data/valid/ready       upstream stream
//            dma_proc_done, dma_mc_err      FPU / memory controller status
//            dma_addr, dma_data, dma_we,
//            dma_cond                       memory controller drive
//            dma_pair, dma_busy,
//            dma_done, dma_err              job status
// Revision : 1.0  initial release
// ============================================================================
module dma_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 7,
  parameter int TIMEOUT = 255
) (
  input  logic              dma_clk,
  input  logic              dma_reset,
  input  logic              dma_start,
  input  logic [ADDR_W-1:0] dma_len,
  input  logic [DATA_W-1:0] dma_src_data,
  input  logic              dma_src_valid,
  output logic              dma_src_ready,
  input  logic              dma_proc_done,
  input  logic              dma_mc_err,
  output logic [ADDR_W-1:0] dma_addr,
  output logic [DATA_W-1:0] dma_data,
  output logic              dma_we,
  output logic [3:0]        dma_cond,
  output logic [5:0]        dma_pair,
  output logic              dma_busy,
  output logic              dma_done,
  output logic              dma_err
);

  localparam logic [3:0] COND_STORE = 4'b0000;
  localparam logic [3:0] COND_XFER  = 4'b1100;
  localparam logic [3:0] COND_PROC  = 4'b1111;
  localparam logic [3:0] COND_PDONE = 4'b1110;
  // PROC lasts at most TIMEOUT cycles; the wait counter reads 0 on the first.
  localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FLUSH, S_XFER_A, S_XFER_B, S_PROC, S_DONE, S_FINISH
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] len_q, len_nx;
  logic [ADDR_W-1:0] wcnt, wcnt_nx;
  logic [5:0]        pair, pair_nx, pair_inc;
  logic [7:0]        wait_cnt, wait_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] data_nx;
  logic              we_nx, done_nx, err_nx;
  logic [3:0]        cond_nx;
  logic              len_ok, last_pair;

  assign len_ok    = (dma_len >= ADDR_W'(2)) && (32'(dma_len) <= 32'd126) && !dma_len[0];
  assign pair_inc  = pair + 6'd1;
  assign last_pair = (ADDR_W'(pair_inc) == (len_q >> 1));

  assign dma_src_ready = (state == S_LOAD);
  assign dma_busy      = (state != S_IDLE);
  assign dma_pair      = pair;

  // Registered outputs are computed for the state being entered, so each
  // output lines up with the state it belongs to.
  always_comb begin
    state_nx = state;
    len_nx   = len_q;
    wcnt_nx  = wcnt;
    pair_nx  = pair;
    wait_nx  = wait_cnt;
    addr_nx  = dma_addr;
    data_nx  = dma_data;
    we_nx    = 1'b0;
    cond_nx  = COND_STORE;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    if (state != S_IDLE && dma_mc_err) begin
      state_nx = S_IDLE;
      err_nx   = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (dma_start) begin
            if (len_ok) begin
              len_nx   = dma_len;
              wcnt_nx  = '0;
              pair_nx  = '0;
              state_nx = S_LOAD;
            end else begin
              err_nx = 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (dma_src_valid) begin
            we_nx   = 1'b1;
            data_nx = dma_src_data;
            addr_nx = wcnt;
            wcnt_nx = wcnt + 1'b1;
            if (wcnt == len_q - 1'b1) state_nx = S_FLUSH;
          end
        end
        S_FLUSH: begin
          state_nx = S_XFER_A;
          cond_nx  = COND_XFER;
          addr_nx  = ADDR_W'({pair, 1'b0});
        end
        S_XFER_A: begin
          state_nx = S_XFER_B;
          cond_nx  = COND_XFER;
          addr_nx  = ADDR_W'({pair, 1'b1});
        end
        S_XFER_B: begin
          state_nx = S_PROC;
          cond_nx  = COND_PROC;
          wait_nx  = '0;
        end
        S_PROC: begin
          // proc_done is checked first so it wins over a same-cycle timeout.
          if (dma_proc_done) begin
            state_nx = S_DONE;
            cond_nx  = COND_PDONE;
          end else if (wait_cnt == WAIT_LAST) begin
            state_nx = S_IDLE;
            err_nx   = 1'b1;
          end else begin
            cond_nx = COND_PROC;
            wait_nx = wait_cnt + 8'd1;
          end
        end
        S_DONE: begin
          pair_nx = pair_inc;
          if (last_pair) begin
            state_nx = S_FINISH;
            done_nx  = 1'b1;
          end else begin
            state_nx = S_XFER_A;
            cond_nx  = COND_XFER;
            addr_nx  = ADDR_W'({pair_inc, 1'b0});
          end
        end
        S_FINISH: state_nx = S_IDLE;
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge dma_clk) begin
    if (!dma_reset) begin
      state    <= S_IDLE;
      len_q    <= '0;
      wcnt     <= '0;
      pair     <= '0;
      wait_cnt <= '0;
      dma_addr <= '0;
      dma_data <= '0;
      dma_we   <= 1'b0;
      dma_cond <= COND_STORE;
      dma_done <= 1'b0;
      dma_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      len_q    <= len_nx;
      wcnt     <= wcnt_nx;
      pair     <= pair_nx;
      wait_cnt <= wait_nx;
      dma_addr <= addr_nx;
      dma_data <= data_nx;
      dma_we   <= we_nx;
      dma_cond <= cond_nx;
      dma_done <= done_nx;
      dma_err  <= err_nx;
    end
  end

endmodule
`default_nettype wire

// File: doc/dma_ctrl.md
DMA_CTRL -- requirements
Module: dma_ctrl

Interface
REQ-001 Parameter DATA_W, 32, width of data words.
REQ-002 Parameter ADDR_W, 7, width of the memory word address.
REQ-003 Parameter TIMEOUT, 255, maximum cycles spent in PROC waiting for dma_proc_done.
REQ-004 dma_clk  in  1  single clock; all logic on its rising edge.
REQ-005 dma_reset  in  1  reset; synchronous, active-low.
REQ-006 dma_start  in  1  request a job; sampled only in IDLE.
REQ-007 dma_len  in  ADDR_W  job length in words; must be even and in the range 2..126.
REQ-008 dma_src_data  in  DATA_W  input word from the upstream stream.
REQ-009 dma_src_valid  in  1  upstream word valid.
REQ-010 dma_src_ready  out  1  block accepts a word; the word transfers on a cycle with valid&&ready.
REQ-011 dma_proc_done  in  1  FPU finished the current operand pair.
REQ-012 dma_mc_err  in  1  error flag from the memory controller.
REQ-013 dma_addr  out  ADDR_W  memory controller word address.
REQ-014 dma_data  out  DATA_W  write data to the memory controller.
REQ-015 dma_we  out  1  write enable to the memory controller.
REQ-016 dma_cond  out  4  condition code to the memory controller.
REQ-017 dma_pair  out  6  index of the operand pair in progress.
REQ-018 dma_busy  out  1  high in every state except IDLE.
REQ-019 dma_done  out  1  one-cycle pulse when a job completes.
REQ-020 dma_err  out  1  one-cycle pulse when a job is aborted or rejected.

Function
REQ-021 The block SHALL be the initiator that drives the memory controller through the condition-code sequence 0000 (store), 1100 (transfer), 1111 (process), 1110 (process done).
REQ-022 The state machine SHALL have the states IDLE, LOAD, FLUSH, XFER_A, XFER_B, PROC, DONE and FINISH.
REQ-023 The state, dma_addr, dma_data, dma_we, dma_cond, dma_done and dma_err SHALL all be registered outputs.
REQ-024 dma_src_ready SHALL be high exactly when the state is LOAD.
REQ-025 In IDLE, dma_start with a legal dma_len SHALL latch dma_len, clear the word and pair counters, and move to LOAD.
REQ-026 In IDLE, dma_start with dma_len odd, 0, or above 126 SHALL pulse dma_err for one cycle, and the block SHALL stay in IDLE.
REQ-027 In IDLE, PROC-less states and LOAD/FLUSH, dma_cond SHALL be 0000.
REQ-028 In LOAD, each accepted word SHALL drive, on the next cycle, dma_we=1, dma_data=word and dma_addr=word index (0,1,2,...).
REQ-029 In LOAD, dma_we SHALL be 0 on any cycle that follows a cycle without a handshake.
REQ-030 Acceptance of word len-1 SHALL move the block to FLUSH, which presents the last write, and then to XFER_A unconditionally.
REQ-031 XFER_A SHALL drive dma_cond=1100, dma_we=0 and dma_addr=2*pair for one cycle.
REQ-032 XFER_B SHALL drive dma_cond=1100, dma_we=0 and dma_addr=2*pair+1 for one cycle, then move to PROC.
REQ-033 PROC SHALL drive dma_cond=1111 and clear an 8-bit wait counter on entry.
REQ-034 PROC SHALL move to DONE when dma_proc_done=1.
REQ-035 PROC SHALL pulse dma_err and move to IDLE when the wait counter reaches TIMEOUT without dma_proc_done.
REQ-036 If dma_proc_done and the timeout occur in the same cycle, dma_proc_done SHALL win.
REQ-037 DONE SHALL drive dma_cond=1110 for one cycle and increment the pair counter.
REQ-038 DONE SHALL move to FINISH when the incremented pair count equals len/2, and to XFER_A otherwise.
REQ-039 FINISH SHALL pulse dma_done for one cycle, drive dma_cond=0000, and move to IDLE.
REQ-040 dma_mc_err=1 in any state other than IDLE SHALL abort the job: next cycle IDLE, dma_we=0, dma_cond=0000, and a one-cycle dma_err pulse.
REQ-041 dma_mc_err SHALL take priority over all other transitions.
REQ-042 dma_start SHALL be ignored outside IDLE.
REQ-043 dma_proc_done SHALL be ignored outside PROC.
REQ-044 The word counter SHALL be ADDR_W bits wide and SHALL never wrap, because the legal length is at most 126.

Reset
REQ-045 While dma_reset=0 at a clock edge, the block SHALL enter IDLE and drive dma_addr=0, dma_data=0, dma_we=0, dma_cond=0000, dma_pair=0, dma_busy=0, dma_done=0, dma_err=0 and dma_src_ready=0.
REQ-046 A reset asserted mid-job SHALL discard the job with no dma_done or dma_err pulse.

Verification
REQ-047 dma_len=4, words 0xA0..0xA3 with valid held high, dma_proc_done two cycles after each PROC entry -> writes to addresses 0..3; then XFER addresses 0,1 and 2,3; dma_cond 1100/1111/1110 twice; one dma_done pulse.
REQ-048 dma_len=2 with dma_src_valid toggling 1,0,1 -> dma_we high only on the cycles after the two handshakes; dma_addr 0 then 1.
REQ-049 dma_start with dma_len=3, and separately with dma_len=0 -> a single-cycle dma_err each time; dma_busy stays 0.
REQ-050 dma_proc_done never asserted in PROC -> dma_err after 255 PROC cycles; IDLE on the next cycle.
REQ-051 dma_mc_err pulsed during LOAD after 3 words of an 8-word job -> IDLE next cycle, dma_we=0, dma_err pulse, no dma_done.
REQ-052 dma_reset low during PROC of pair 1 -> all outputs at their reset values; a new dma_len=2 job then completes normally with dma_pair starting at 0.
